// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared constants for the register-bus transfer sequencer.
//   - FSM state encodings (IDLE, DRIVE, LATCH, DONE)
//   - CS_IDLE: chip-select pattern with every register released (all ones),
//     sized for the largest supported register count; users slice it.
package reg_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MAX_REGS = 16;
  localparam logic [MAX_REGS-1:0] CS_IDLE = '1;

endpackage

// File: rtl/reg_bus_addr_decoder.sv
// reg_bus_addr_decoder: register index to one-hot select vector.
// Ports:
//   idx_i  register index
//   en_i   when 0 the one-hot output is all zeros
//   hot_o  one-hot select, bit idx_i set when enabled and in range
//   oor_o  index addresses no existing register (idx_i >= NrOfRegs)
module reg_bus_addr_decoder #(
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
) (
  input  logic [AddrBits-1:0] idx_i,
  input  logic                en_i,
  output logic [NrOfRegs-1:0] hot_o,
  output logic                oor_o
);

  always_comb begin
    hot_o = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (en_i && (32'(idx_i) == i)) hot_o[i] = 1'b1;
    end
  end

  assign oor_o = (32'(idx_i) >= NrOfRegs);

endmodule

// File: rtl/reg_bus_transfer_ctrl.sv
// reg_bus_transfer_ctrl: sequences one register-to-register or
// immediate-to-register transfer on a shared tri-state register bus.
//
// state | meaning
// IDLE  | waiting for req; request fields captured when it arrives
// DRIVE | source drives the bus (cs[src]=0 or immediate), bus settles
// LATCH | bus held, load_en[dst]=1 so the destination latches this edge
// DONE  | bus released, done pulse with err
//
// Ports:
//   Clock, Reset      clock, asynchronous active-high reset
//   Tick              advance qualifier; nothing changes while 0
//   req/imm_sel/src/dst/imm_data  transfer request
//   bus               shared register bus (driven here only for immediates)
//   cs                per-register output disable (1 = high-Z)
//   load_en           per-register ClockEnable
//   busy/done/err     handshake status, err valid with done
//   snoop_data        last bus value latched in LATCH
// Build option: REG_BUS_SNOOP_EN enables the snoop_data capture register;
// without it snoop_data is constant zero.
import reg_bus_pkg::*;

module reg_bus_transfer_ctrl #(
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3,
  parameter int NrOfBits = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req,
  input  logic                imm_sel,
  input  logic [AddrBits-1:0] src,
  input  logic [AddrBits-1:0] dst,
  input  logic [NrOfBits-1:0] imm_data,
  inout  wire  [NrOfBits-1:0] bus,
  output logic [NrOfRegs-1:0] cs,
  output logic [NrOfRegs-1:0] load_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NrOfBits-1:0] snoop_data
);

  logic [1:0]          state_q, state_d;
  logic                imm_sel_q, imm_sel_d;
  logic [AddrBits-1:0] src_q, src_d;
  logic [AddrBits-1:0] dst_q, dst_d;
  logic [NrOfBits-1:0] imm_q, imm_d;
  logic                err_flag_q, err_flag_d;

  logic [NrOfRegs-1:0] cs_q, cs_d;
  logic [NrOfRegs-1:0] load_en_q, load_en_d;
  logic                drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // In IDLE the outputs for the next step are computed from the request
  // being captured on this edge; afterwards from the captured copy.
  logic                in_idle;
  logic                sel_imm;
  logic [AddrBits-1:0] sel_src, sel_dst;
  logic [NrOfRegs-1:0] src_hot, dst_hot;
  logic                src_oor, dst_oor;
  logic                req_bad;

  assign in_idle = (state_q == ST_IDLE);
  assign sel_imm = in_idle ? imm_sel : imm_sel_q;
  assign sel_src = in_idle ? src     : src_q;
  assign sel_dst = in_idle ? dst     : dst_q;

  reg_bus_addr_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_src_dec (
    .idx_i (sel_src),
    .en_i  (~sel_imm),
    .hot_o (src_hot),
    .oor_o (src_oor)
  );

  reg_bus_addr_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_dst_dec (
    .idx_i (sel_dst),
    .en_i  (1'b1),
    .hot_o (dst_hot),
    .oor_o (dst_oor)
  );

  // src is irrelevant for immediates, so its range only matters otherwise.
  assign req_bad = dst_oor | (~sel_imm & src_oor);

  always_comb begin
    state_d    = state_q;
    imm_sel_d  = imm_sel_q;
    src_d      = src_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          imm_sel_d  = imm_sel;
          src_d      = src;
          dst_d      = dst;
          imm_d      = imm_data;
          err_flag_d = req_bad;
          state_d    = req_bad ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are
  // glitch-free. src_hot is all zeros for immediates, keeping cs released
  // whenever this block drives the bus.
  always_comb begin
    cs_d      = CS_IDLE[NrOfRegs-1:0];
    load_en_d = '0;
    drive_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_d)
      ST_DRIVE: begin
        busy_d  = 1'b1;
        drive_d = sel_imm;
        cs_d    = ~src_hot;
      end
      ST_LATCH: begin
        busy_d    = 1'b1;
        drive_d   = sel_imm;
        cs_d      = ~src_hot;
        load_en_d = dst_hot;
      end
      ST_DONE: begin
        done_d = 1'b1;
        err_d  = err_flag_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      imm_sel_q  <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      err_flag_q <= 1'b0;
      cs_q       <= CS_IDLE[NrOfRegs-1:0];
      load_en_q  <= '0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (Tick) begin
      state_q    <= state_d;
      imm_sel_q  <= imm_sel_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      err_flag_q <= err_flag_d;
      cs_q       <= cs_d;
      load_en_q  <= load_en_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus     = drive_q ? imm_q : {NrOfBits{1'bz}};
  assign cs      = cs_q;
  assign load_en = load_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

`ifdef REG_BUS_SNOOP_EN
  logic [NrOfBits-1:0] snoop_q;

  // Captures alongside the destination register, on the LATCH edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                          snoop_q <= '0;
    else if (Tick && state_q == ST_LATCH) snoop_q <= bus;
  end

  assign snoop_data = snoop_q;
`else
  assign snoop_data = '0;
`endif

endmodule

// File: tb/tb_reg_bus_transfer_ctrl.sv
module tb_reg_bus_transfer_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Tick;
  logic        req, imm_sel;
  logic [2:0]  src, dst;
  logic [15:0] imm_data;
  wire  [15:0] bus;
  logic [7:0]  cs, le;
  logic        busy, done, err;
  logic [15:0] snoop;

  logic        req6, imm_sel6;
  logic [2:0]  src6, dst6;
  logic [15:0] imm6;
  wire  [15:0] bus6;
  logic [5:0]  cs6, le6;
  logic        busy6, done6, err6;
  logic [15:0] snoop6;

  always #5 Clock = ~Clock;

`ifdef REG_BUS_SNOOP_EN
  localparam logic [15:0] EXP_SNOOP = 16'h1234;
`else
  localparam logic [15:0] EXP_SNOOP = 16'h0000;
`endif

  reg_bus_transfer_ctrl #(.NrOfRegs(8), .AddrBits(3), .NrOfBits(16)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req), .imm_sel(imm_sel),
    .src(src), .dst(dst), .imm_data(imm_data), .bus(bus), .cs(cs),
    .load_en(le), .busy(busy), .done(done), .err(err), .snoop_data(snoop)
  );

  reg_bus_transfer_ctrl #(.NrOfRegs(6), .AddrBits(3), .NrOfBits(16)) dut6 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req6), .imm_sel(imm_sel6),
    .src(src6), .dst(dst6), .imm_data(imm6), .bus(bus6), .cs(cs6),
    .load_en(le6), .busy(busy6), .done(done6), .err(err6), .snoop_data(snoop6)
  );

  // Register file model on the main bus.
  logic [15:0] regs [8];
  logic        pre_en;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;
  logic        tb_oe;
  logic [15:0] tb_val;

  always_comb begin
    tb_oe  = 1'b0;
    tb_val = '0;
    for (int i = 0; i < 8; i++) begin
      if (!cs[i]) begin
        tb_oe  = 1'b1;
        tb_val = regs[i];
      end
    end
  end

  assign bus = tb_oe ? tb_val : 16'hzzzz;

  always @(posedge Clock) begin
    if (pre_en) regs[pre_idx] <= pre_val;
    else begin
      for (int i = 0; i < 8; i++) begin
        if (le[i] && Tick) regs[i] <= bus;
      end
    end
  end

  typedef struct {
    int          dst;
    logic [15:0] val;
  } sb_t;
  sb_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    sb_t e;
    total++;
    assert (sbq.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(tag, {16'h0, regs[e.dst]}, {16'h0, e.val});
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("done_timeout", {31'h0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Tick = 1'b1; req = 1'b0; imm_sel = 1'b0; src = '0; dst = '0;
    imm_data = '0; req6 = 1'b0; imm_sel6 = 1'b0; src6 = '0; dst6 = '0; imm6 = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    step(); step();
    Reset = 1'b0;
    chk("rst_cs", cs, 8'hFF);
    chk("rst_le", le, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_snoop", snoop, 0);
    chk("rst_cs6", cs6, 6'h3F);
    chk("rst_snoop6", snoop6, 0);

    pre_en = 1'b1; pre_idx = 3'd2; pre_val = 16'hBEEF;
    step();
    pre_en = 1'b0;

    // register 2 -> register 5
    src = 3'd2; dst = 3'd5; req = 1'b1; sbq.push_back('{5, 16'hBEEF});
    step(); req = 1'b0;
    chk("r2r_c1_cs", cs, 8'hFB);
    chk("r2r_c1_le", le, 8'h00);
    chk("r2r_c1_busy", busy, 1);
    step();
    chk("r2r_c2_le", le, 8'h20);
    chk("r2r_c2_cs", cs, 8'hFB);
    step();
    chk("r2r_c3_done", done, 1);
    chk("r2r_c3_err", err, 0);
    chk("r2r_c3_cs", cs, 8'hFF);
    sb_pop("r2r_reg5");
    step();
    chk("r2r_c4_done", done, 0);

    // immediate 0x1234 -> register 0
    imm_sel = 1'b1; imm_data = 16'h1234; src = 3'd7; dst = 3'd0; req = 1'b1;
    sbq.push_back('{0, 16'h1234});
    step(); req = 1'b0;
    chk("imm_c1_bus", bus, 16'h1234);
    chk("imm_c1_cs", cs, 8'hFF);
    step();
    chk("imm_c2_bus", bus, 16'h1234);
    chk("imm_c2_cs", cs, 8'hFF);
    chk("imm_c2_le", le, 8'h01);
    step();
    chk("imm_c3_done", done, 1);
    sb_pop("imm_reg0");
    chk("imm_snoop", snoop, EXP_SNOOP);
    imm_sel = 1'b0;
    step();

    // Tick stall in DRIVE: register 5 -> register 3
    src = 3'd5; dst = 3'd3; req = 1'b1; sbq.push_back('{3, 16'hBEEF});
    step(); req = 1'b0; Tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_cs", cs, 8'hDF);
      chk("stall_le", le, 8'h00);
      chk("stall_busy", busy, 1);
    end
    Tick = 1'b1;
    step();
    chk("stall_latch_le", le, 8'h08);
    chk("stall_latch_cs", cs, 8'hDF);
    step();
    chk("stall_done", done, 1);
    sb_pop("stall_reg3");
    step();

    // error paths on the 6-register instance
    dst6 = 3'd7; src6 = 3'd0; req6 = 1'b1;
    step(); req6 = 1'b0;
    chk("err_dst_done", done6, 1);
    chk("err_dst_err", err6, 1);
    chk("err_dst_cs", cs6, 6'h3F);
    chk("err_dst_le", le6, 6'h00);
    chk("err_dst_busy", busy6, 0);
    step();
    chk("err_dst_idle", done6, 0);
    src6 = 3'd6; dst6 = 3'd1; req6 = 1'b1;
    step(); req6 = 1'b0;
    chk("err_src_done", done6, 1);
    chk("err_src_err", err6, 1);
    step();
    src6 = 3'd5; dst6 = 3'd0; req6 = 1'b1;
    step(); req6 = 1'b0;
    chk("ok6_c1_cs", cs6, 6'h1F);
    step();
    chk("ok6_c2_le", le6, 6'h01);
    step();
    chk("ok6_c3_done", done6, 1);
    chk("ok6_c3_err", err6, 0);
    step();

    // reset during LATCH
    src = 3'd0; dst = 3'd1; req = 1'b1;
    step(); req = 1'b0;
    chk("rstl_c1_cs", cs, 8'hFE);
    step();
    chk("rstl_c2_le", le, 8'h02);
    #2 Reset = 1'b1;
    #1;
    chk("rstl_cs", cs, 8'hFF);
    chk("rstl_le", le, 8'h00);
    chk("rstl_busy", busy, 0);
    chk("rstl_done", done, 0);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    src = 3'd2; dst = 3'd6; req = 1'b1; sbq.push_back('{6, 16'hBEEF});
    step(); req = 1'b0;
    wait_done(6);
    sb_pop("rstl_reg6");
    step();

    // back-to-back: req held high through the first transfer
    src = 3'd0; dst = 3'd4; req = 1'b1; sbq.push_back('{4, 16'h1234});
    step();
    chk("b2b_c1_cs", cs, 8'hFE);
    src = 3'd2; dst = 3'd7; sbq.push_back('{7, 16'hBEEF});
    step();
    step();
    chk("b2b_c3_done", done, 1);
    sb_pop("b2b_reg4");
    step();
    chk("b2b_c4_busy", busy, 0);
    chk("b2b_c4_done", done, 0);
    step(); req = 1'b0;
    chk("b2b_c5_busy", busy, 1);
    chk("b2b_c5_cs", cs, 8'hFB);
    step();
    step();
    chk("b2b_c7_done", done, 1);
    sb_pop("b2b_reg7");
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
